// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate extender: mode encodings,
// op width and default immediate/output widths.
package imm_ext_pkg;

    localparam int OP_W      = 2;
    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 32;

    localparam logic [OP_W-1:0] EXT_ZERO   = 2'b00;
    localparam logic [OP_W-1:0] EXT_SIGN   = 2'b01;
    localparam logic [OP_W-1:0] EXT_UPPER  = 2'b10;
    localparam logic [OP_W-1:0] EXT_BRANCH = 2'b11;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational mode mux: widens an IN_W-bit immediate to OUT_W bits
// using zero, sign, upper (LUI) or branch-offset extension.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int BR_SHIFT = 2
) (
    input  logic [IN_W-1:0]  in_imm,
    input  logic [OP_W-1:0]  in_op,
    output logic [OUT_W-1:0] ext_data
);

    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] upper_ext;
    logic [OUT_W-1:0] branch_ext;

    // When the widths match every extension degenerates to the raw
    // immediate, and zero-width replications must be avoided.
    generate
        if (OUT_W > IN_W) begin : g_wide
            assign zero_ext  = {{(OUT_W-IN_W){1'b0}}, in_imm};
            assign sign_ext  = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
            assign upper_ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
        end else begin : g_equal
            assign zero_ext  = in_imm;
            assign sign_ext  = in_imm;
            assign upper_ext = in_imm;
        end
    endgenerate

    // Branch offsets are word-scaled sign extensions; bits shifted past
    // the top are simply dropped.
    assign branch_ext = sign_ext << BR_SHIFT;

    // Select the extension requested by the decoder.
    always_comb begin
        ext_data = zero_ext;
        case (in_op)
            EXT_ZERO:   ext_data = zero_ext;
            EXT_SIGN:   ext_data = sign_ext;
            EXT_UPPER:  ext_data = upper_ext;
            EXT_BRANCH: ext_data = branch_ext;
            default:    ext_data = zero_ext;
        endcase
    end

endmodule

// File: rtl/imm_ext_unit.sv
// Immediate extender with a 2-entry valid/ready output buffer and
// synchronous flush. Optional accepted-transaction counter enabled by
// defining IMM_EXT_CNT_EN; otherwise ext_cnt is tied to zero.
module imm_ext_unit
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [15:0]      ext_cnt
);

    localparam logic [1:0] CNT_FULL = 2'd2;

    logic [OUT_W-1:0] ext_data;
    logic [1:0]       count_reg;
    logic [1:0]       count_next;
    logic             wr_ptr_reg;
    logic             wr_ptr_next;
    logic             rd_ptr_reg;
    logic             rd_ptr_next;
    logic             push;
    logic             push_eff;
    logic             pop;

    imm_ext_core #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .in_imm   (in_imm),
        .in_op    (in_op),
        .ext_data (ext_data)
    );

    // Ready depends only on state (and reset), never on out_ready, so a
    // stalled consumer cannot form a combinational loop back to decode.
    assign in_ready  = !rst && (count_reg != CNT_FULL);
    assign out_valid = (count_reg != 2'd0);

    assign push     = in_valid && in_ready;
    // A beat offered during flush looks accepted but is dropped.
    assign push_eff = push && !flush;
    assign pop      = out_valid && out_ready;

    // Next-state for occupancy and pointers; pointers wrap naturally
    // because they are one bit wide.
    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            count_next  = 2'd0;
            wr_ptr_next = 1'b0;
            rd_ptr_next = 1'b0;
        end else begin
            case ({push_eff, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
            if (push_eff) begin
                wr_ptr_next = ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
        end
    end

    // Occupancy and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // One storage slot per buffer entry; the slot addressed by the write
    // pointer captures the already-extended value.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [OUT_W-1:0] data_reg;

            // Capture the extended immediate on an effective push.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (push_eff && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= ext_data;
                end
            end
        end
    endgenerate

    // Head of buffer is purely a register select, no input bypass.
    assign out_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;

`ifdef IMM_EXT_CNT_EN
    logic [15:0] ext_cnt_reg;

    // Saturating count of effective pushes; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_cnt_reg <= 16'h0000;
        end else if (push_eff && (ext_cnt_reg != 16'hFFFF)) begin
            ext_cnt_reg <= ext_cnt_reg + 16'h0001;
        end
    end

    assign ext_cnt = ext_cnt_reg;
`else
    assign ext_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_imm_ext_unit.sv
// Scoreboard testbench for imm_ext_unit: default-parameter instance
// checked through an expected-value queue, plus an 8->16 bit instance.
module tb_imm_ext_unit;
    import imm_ext_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [15:0] ext_cnt;

    logic        p_valid = 1'b0;
    logic        p_ready;
    logic [7:0]  p_imm = '0;
    logic [1:0]  p_op = '0;
    logic        p_out_valid;
    logic [15:0] p_out_data;
    logic [15:0] p_cnt;

    int          nchecks = 0;
    int          nerr = 0;
    int          exp_cnt = 0;
    bit          mon_en = 1'b1;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    imm_ext_unit dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .ext_cnt(ext_cnt)
    );

    imm_ext_unit #(.IN_W(8), .OUT_W(16), .BR_SHIFT(1)) dut8 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(p_valid), .in_ready(p_ready),
        .in_imm(p_imm), .in_op(p_op),
        .out_valid(p_out_valid), .out_ready(1'b1),
        .out_data(p_out_data), .ext_cnt(p_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [31:0] cnt_exp();
`ifdef IMM_EXT_CNT_EN
        return 32'(exp_cnt);
`else
        return 32'h0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and wait (bounded) until it is accepted; the
    // expected extension enters the scoreboard at the accepting edge.
    task automatic send(input logic [1:0] op, input logic [15:0] imm, input logic [31:0] exp);
        int w = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_imm   = imm;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'h1);
        end else begin
            @(posedge clk);
            exp_q.push_back(exp);
            if (exp_cnt < 65535) exp_cnt++;
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send8(input logic [1:0] op, input logic [7:0] imm, input logic [15:0] exp, input string name);
        p_valid = 1'b1;
        p_op    = op;
        p_imm   = imm;
        tick();
        p_valid = 1'b0;
        check(name, {15'h0, p_out_valid, p_out_data}, {15'h0, 1'b1, exp});
        tick();
    endtask

    // Monitor: every beat the consumer takes must match the queue head.
    always @(negedge clk) begin
        if (mon_en && !rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", out_data, 32'hDEADDEAD);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        tick();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_ext_cnt", 32'(ext_cnt), 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'h1);

        // Modes, with one-cycle latency checked directly.
        out_ready = 1'b1;
        send(EXT_SIGN, 16'h8001, 32'hFFFF8001);
        check("lat_sign", {out_valid, out_data[30:0]}, {1'b1, 31'h7FFF8001});
        send(EXT_ZERO, 16'h8001, 32'h00008001);
        check("lat_zero", out_data, 32'h00008001);
        send(EXT_UPPER, 16'h1234, 32'h12340000);
        check("lat_upper", out_data, 32'h12340000);
        send(EXT_BRANCH, 16'hFFFF, 32'hFFFFFFFC);
        check("lat_branch", out_data, 32'hFFFFFFFC);
        tick();
        check("drained", 32'(out_valid), 32'h0);

        // Backpressure: two beats fill the buffer, third waits.
        out_ready = 1'b0;
        send(EXT_SIGN, 16'h0001, 32'h1);
        send(EXT_SIGN, 16'h0002, 32'h2);
        check("full_in_ready", 32'(in_ready), 32'h0);
        fork
            send(EXT_SIGN, 16'h0003, 32'h3);
            begin
                repeat (3) tick();
                out_ready = 1'b1;
            end
        join
        repeat (3) tick();
        check("bp_queue_empty", 32'(exp_q.size()), 32'h0);

        // Flush with two entries and a blocked beat offered.
        out_ready = 1'b0;
        send(EXT_ZERO, 16'h0011, 32'h11);
        send(EXT_ZERO, 16'h0022, 32'h22);
        flush = 1'b1; in_valid = 1'b1; in_op = EXT_ZERO; in_imm = 16'h00AA;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        check("flush_out_valid", 32'(out_valid), 32'h0);
        check("flush_in_ready", 32'(in_ready), 32'h1);
        check("flush_ext_cnt", 32'(ext_cnt), cnt_exp());

        // Flush with one entry: the offered beat looks accepted but is lost.
        send(EXT_ZERO, 16'h0033, 32'h33);
        flush = 1'b1; in_valid = 1'b1; in_imm = 16'h00AA;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        check("flush1_out_valid", 32'(out_valid), 32'h0);
        check("flush1_ext_cnt", 32'(ext_cnt), cnt_exp());
        out_ready = 1'b1;
        send(EXT_ZERO, 16'h0055, 32'h55);
        tick();

        // Reset mid-stream with one entry buffered.
        out_ready = 1'b0;
        send(EXT_SIGN, 16'h7777, 32'h7777);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_out_data", out_data, 32'h0);
        check("midrst_ext_cnt", 32'(ext_cnt), 32'h0);
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        #1;
        check("midrst_ready_after", 32'(in_ready), 32'h1);

        // Five pushes with simultaneous pops.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(EXT_ZERO, 16'(i + 1), 32'(i + 1));
        end
        tick();
        check("cnt_five", 32'(ext_cnt), cnt_exp());

        // Parameter sweep on the narrow instance.
        send8(EXT_SIGN, 8'h80, 16'hFF80, "p8_sign");
        send8(EXT_BRANCH, 8'h80, 16'hFF00, "p8_branch");
        send8(EXT_UPPER, 8'h12, 16'h1200, "p8_upper");

`ifdef IMM_EXT_CNT_EN
        // Saturation: stream far past 16 bits with output unblocked.
        mon_en = 1'b0;
        in_valid = 1'b1; in_op = EXT_ZERO; in_imm = 16'h0001;
        repeat (65540) tick();
        in_valid = 1'b0;
        tick();
        check("cnt_saturate", 32'(ext_cnt), 32'h0000FFFF);
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/imm_ext_unit.md
Name: imm_ext_unit

Overview:
- Parametrised, multi-mode immediate extender for the single-cycle/multicycle MIPS datapath.
- Widens an IN_W-bit instruction immediate to OUT_W bits using one of four modes: zero, sign, LUI-upper and branch-offset.
- Results pass through a 2-entry valid/ready output buffer, so the block sits between decode and the ALU B-operand mux and can absorb one cycle of backpressure.
- Synchronous flush squashes buffered immediates on a branch or jump redirect.

Parameters:
- IN_W, 16, immediate input width (≥1).
- OUT_W, 32, extended output width (≥IN_W).
- BR_SHIFT, 2, left shift applied in branch-offset mode (0..OUT_W-1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous clear of all buffered entries.
- in_valid  in  1  in_imm/in_op valid.
- in_ready  out  1  buffer can accept this cycle.
- in_imm  in  IN_W  raw immediate.
- in_op  in  2  extension mode (encodings below).
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  OUT_W  extended immediate, head of buffer.
- ext_cnt  out  16  accepted-transaction counter (optional feature).

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Mode encodings (in_op):
  - 2'b00 ZERO: {zeros, imm}.
  - 2'b01 SIGN: {OUT_W-IN_W copies of imm[IN_W-1], imm}.
  - 2'b10 UPPER: imm << (OUT_W-IN_W); low bits zero. When OUT_W==IN_W, result = imm.
  - 2'b11 BRANCH: SIGN result << BR_SHIFT, truncated to OUT_W.
- Extension is combinational on the input side. The result is written into the buffer, never the raw immediate.
- Buffer:
  - 2-entry FIFO with a 2-bit count (0..2), 1-bit write pointer and 1-bit read pointer.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Handshake signals:
  - in_ready = !rst & (count != 2). It is combinational from state only and does not depend on out_ready.
  - out_valid = (count != 0). out_data = entry[rd_ptr]. Both are registered state.
- Latency: an immediate accepted in cycle N is visible on out_data in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop:
  - count 1: count stays 1, both pointers advance, and the new entry follows.
  - count 2: no push is possible (in_ready=0); the pop alone gives count=1.
  - count 0: no pop is possible; the push alone gives count=1.
- Pointers wrap modulo 2.
- Flush: on the next edge, count=0 and both pointers=0. A push in the same cycle is discarded. in_ready is still shown as 1 when count<2, but the beat is lost. flush has lower priority than rst.
- Reset values: count=0, pointers=0, storage=0, out_valid=0, out_data=0, ext_cnt=0, in_ready=0 while rst is high.
- Reset mid-operation discards all entries. in_ready rises in the first cycle after rst deasserts.
- Inputs are don't-care when in_valid=0.

Optional Feature:
- IMM_EXT_CNT_EN defined:
  - ext_cnt increments by 1 on every push, saturating at 16'hFFFF.
  - It is cleared by rst only; flush does not clear it.
  - A push discarded by flush is not counted.
- Undefined: ext_cnt is tied to 16'h0000 and no counter register exists.

Decomposition:
- Shared package/header imm_ext_pkg: EXT_ZERO, EXT_SIGN, EXT_UPPER, EXT_BRANCH op constants, the op width (2) and the default IN_W/OUT_W.
- Natural sub-module: imm_ext_core, the purely combinational mode mux (in_imm, in_op → extended value, same parameters).
- imm_ext_unit holds the FIFO, handshake, flush and counter logic.

Test Plan:
- Modes (defaults, out_ready=1):
  - SIGN 16'h8001 → 32'hFFFF8001.
  - ZERO 16'h8001 → 32'h00008001.
  - UPPER 16'h1234 → 32'h12340000.
  - BRANCH 16'hFFFF → 32'hFFFFFFFC.
  - Each appears one cycle after acceptance.
- Backpressure: out_ready=0, push 16'h0001 then 16'h0002 (SIGN) → in_ready=0 after the second. Hold a third beat 16'h0003 valid. Raise out_ready → outputs 0x1, 0x2, 0x3 in order with no loss or duplication.
- Flush: buffer holding 2 entries, assert flush with in_valid=1 imm 16'h00AA → next cycle out_valid=0, in_ready=1. The 0xAA beat never appears and ext_cnt is unchanged.
- Reset mid-stream: count=1, assert rst one cycle → out_valid=0, out_data=0, ext_cnt=0, in_ready=0 during rst and 1 the cycle after.
- Parameter sweep: IN_W=8, OUT_W=16, BR_SHIFT=1 → SIGN 8'h80 gives 16'hFF80, BRANCH 8'h80 gives 16'hFF00, UPPER 8'h12 gives 16'h1200.
- With IMM_EXT_CNT_EN: 5 accepted pushes with simultaneous pops → ext_cnt=5. Preload near saturation via 65540 pushes → ext_cnt holds 16'hFFFF.
